// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer
//   Sits between the UART receiver and transmitter. Each rising edge of
//   rx_ready captures rx_data_in into a DEPTH x 8 FIFO. A transmit FSM then
//   replays the queued bytes using a one-cycle tx_start pulse and follows
//   tx_busy, with a timeout in case the transmitter never reports busy.
//
//   Parameters:
//     DEPTH        FIFO entries (power of two, >= 2)
//     BUSY_TIMEOUT cycles spent waiting for tx_busy to rise before the byte
//                  counts as sent
//
//   Ports:
//     clk, rst_n     system clock, asynchronous active-low reset
//     rx_ready       receiver byte-valid level (rising edge used)
//     rx_data_in     received byte
//     parity_error   receiver parity flag, qualified with rx_ready
//     tx_busy        transmitter busy
//     tx_start       one-cycle transmit request (registered)
//     tx_data_out    byte to transmit (registered)
//     fifo_count     FIFO occupancy 0..DEPTH
//     overflow       sticky: byte dropped, FIFO full
//     rx_err         sticky: byte dropped, parity error
//
//   Build option:
//     UART_ECHO_CRLF_EN  when defined, a transmitted 0x0D is followed by an
//                        inserted 0x0A using the same handshake.

module uart_echo_buffer #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_ready,
  input  logic [7:0]                 rx_data_in,
  input  logic                       parity_error,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [7:0]                 tx_data_out,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic                       rx_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_NEXT
  } state_t;

  state_t          state, next_state;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            rx_ready_q;
  logic            rx_rise;
  logic            full, empty;
  logic            push, pop, drop_full, drop_parity;
  logic            start_d, load_lf;
  logic            tmo_clr, tmo_inc;
  logic [TW-1:0]   tmo_cnt, tmo_cnt_plus;

  assign rx_rise      = rx_ready & ~rx_ready_q;
  assign full         = (fifo_count == (AW+1)'(DEPTH));
  assign empty        = (fifo_count == '0);
  assign tmo_cnt_plus = tmo_cnt + 1'b1;

  // A push into a full FIFO is still accepted when the FSM pops that cycle.
  assign drop_parity = rx_rise & parity_error;
  assign push        = rx_rise & ~parity_error & (~full | pop);
  assign drop_full   = rx_rise & ~parity_error & full & ~pop;

  // ---------------------------------------------------------------------
  // Transmit FSM: next-state and control
  // ---------------------------------------------------------------------
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    start_d    = 1'b0;
    load_lf    = 1'b0;
    tmo_clr    = 1'b0;
    tmo_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          start_d    = 1'b1;
          next_state = S_START;
        end
      end
      S_START: begin
        tmo_clr    = 1'b1;
        next_state = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          next_state = S_WAIT_DONE;
        end else begin
          tmo_inc = 1'b1;
          if (tmo_cnt_plus == TW'(BUSY_TIMEOUT)) begin
            next_state = S_NEXT;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          next_state = S_NEXT;
        end
      end
      S_NEXT: begin
`ifdef UART_ECHO_CRLF_EN
        // tx_data_out still holds the byte just completed.
        if (tx_data_out == 8'h0D) begin
          load_lf    = 1'b1;
          start_d    = 1'b1;
          next_state = S_START;
        end else begin
          next_state = S_IDLE;
        end
`else
        next_state = S_IDLE;
`endif
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs, timeout counter, capture edge detect
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start    <= 1'b0;
      tx_data_out <= '0;
      tmo_cnt     <= '0;
      rx_ready_q  <= 1'b0;
      overflow    <= 1'b0;
      rx_err      <= 1'b0;
    end else begin
      tx_start   <= start_d;
      rx_ready_q <= rx_ready;
      if (pop) begin
        tx_data_out <= mem[rd_ptr];
      end else if (load_lf) begin
        tx_data_out <= 8'h0A;
      end
      if (tmo_clr) begin
        tmo_cnt <= '0;
      end else if (tmo_inc) begin
        tmo_cnt <= tmo_cnt_plus;
      end
      if (drop_full) begin
        overflow <= 1'b1;
      end
      if (drop_parity) begin
        rx_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data_in;
    end
  end

endmodule
